// File: rtl/spi_slave_shift_pkg.sv
// Shared types and helpers for the SPI responder: FSM states, mode decode, underrun fill.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  typedef struct packed {
    logic sample_rise;
    logic drive_rise;
  } edge_sel_t;

  localparam logic UNDERRUN_FILL_BIT = 1'b1;

  // Leading edge leaves the CKP level; CKE picks whether we sample on it or on the trailing one.
  function automatic edge_sel_t mode_decode(input logic ckp, input logic cke);
    edge_sel_t sel;
    sel.sample_rise = ~(ckp ^ cke);
    sel.drive_rise  = ckp ^ cke;
    return sel;
  endfunction

endpackage

// File: rtl/spi_slave_shift_if.sv
// Pin and word-level bus of the SPI responder.
// With SPI_SLAVE_ERR_FLAGS_EN defined it also carries err_clr and the sticky error flags.
interface spi_slave_shift_if #(parameter int DATA_W = 8);

  logic              CKP;
  logic              CKE;
  logic              sck;
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic              err_clr;
  logic              tx_underrun;
  logic              rx_overrun;
`endif

  modport slave (
    input  CKP, CKE, sck, ss_n, mosi, tx_data, tx_valid,
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    input  err_clr,
    output tx_underrun, rx_overrun,
`endif
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy
  );

  modport master (
    output CKP, CKE, sck, ss_n, mosi, tx_data, tx_valid,
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    output err_clr,
    input  tx_underrun, rx_overrun,
`endif
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy
  );

endinterface

// File: rtl/spi_slave_shift_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus a change strobe;
// rise = edge_o & q_o, fall = edge_o & ~q_o.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic edge_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign edge_o = sync_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/spi_slave_shift.sv
// SPI responder: oversampled pins, all four CKP/CKE modes, one-entry TX buffer, RX strobe.
// Define SPI_SLAVE_ERR_FLAGS_EN to add sticky tx_underrun/rx_overrun flags with err_clr.
module spi_slave_shift
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  spi_slave_shift_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sck_s, sck_edge, ss_s, ss_edge, ss_rise, ss_fall, mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .d_i(bus.sck), .q_o(sck_s), .edge_o(sck_edge)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .d_i(bus.ss_n), .q_o(ss_s), .edge_o(ss_edge)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
  end

  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign ss_rise = ss_edge & ss_s;
  assign ss_fall = ss_edge & ~ss_s;

  state_e            state_q;
  logic [1:0]        mode_q;
  logic              skip_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q, rx_data_q, buf_q;
  logic              miso_q, miso_oe_q, rx_valid_q, buf_full_q;

  edge_sel_t         sel;
  logic              sample_ev, drive_ev, last_bit, complete, load_ev, hs;
  logic [DATA_W-1:0] load_word_d, rx_word_d;

  assign sel         = mode_decode(mode_q[1], mode_q[0]);
  assign sample_ev   = sck_edge && (sck_s == sel.sample_rise);
  assign drive_ev    = sck_edge && (sck_s == sel.drive_rise);
  assign last_bit    = (cnt_q == CNT_W'(DATA_W - 1));
  assign complete    = (state_q == ST_SHIFT) && !ss_rise && sample_ev && last_bit;
  assign load_ev     = ((state_q == ST_LOAD) && !ss_rise) || complete;
  assign load_word_d = buf_full_q ? buf_q : {DATA_W{UNDERRUN_FILL_BIT}};
  assign rx_word_d   = {shift_q[DATA_W-2:0], mosi_s};
  assign hs          = bus.tx_valid && !buf_full_q;

  // ss_n rise is checked first in LOAD/SHIFT so it beats a coincident final sample edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= '0;
      skip_q     <= 1'b0;
      cnt_q      <= '0;
      shift_q    <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (ss_fall) begin
            mode_q  <= {bus.CKP, bus.CKE};
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (ss_rise) begin
            state_q   <= ST_IDLE;
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
          end else begin
            shift_q   <= load_word_d;
            miso_q    <= load_word_d[DATA_W-1];
            miso_oe_q <= 1'b1;
            cnt_q     <= '0;
            skip_q    <= mode_q[0];
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ss_rise) begin
            state_q   <= ST_IDLE;
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
            cnt_q     <= '0;
          end else if (sample_ev) begin
            if (last_bit) begin
              rx_data_q  <= rx_word_d;
              rx_valid_q <= 1'b1;
              cnt_q      <= '0;
              shift_q    <= load_word_d;
              miso_q     <= load_word_d[DATA_W-1];
            end else begin
              shift_q <= rx_word_d;
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end else if (drive_ev) begin
            if (skip_q) skip_q <= 1'b0;
            else        miso_q <= shift_q[DATA_W-1];
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A push landing with a load is stored after the load has taken the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_q <= 1'b0;
      buf_q      <= '0;
    end else if (hs) begin
      buf_q      <= bus.tx_data;
      buf_full_q <= 1'b1;
    end else if (load_ev) begin
      buf_full_q <= 1'b0;
    end
  end

  assign bus.miso     = miso_q;
  assign bus.miso_oe  = miso_oe_q;
  assign bus.tx_ready = ~buf_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = ~ss_s;

`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic           tx_underrun_q, rx_overrun_q, rx_seen_q;
  logic [CNT_W:0] since_q;

  // since_q counts sample edges after the last completion, saturating once outside the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_underrun_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      rx_seen_q     <= 1'b0;
      since_q       <= '0;
    end else begin
      if (load_ev && !buf_full_q) tx_underrun_q <= 1'b1;
      else if (bus.err_clr)       tx_underrun_q <= 1'b0;

      if (complete && rx_seen_q && (since_q < (CNT_W+1)'(DATA_W))) rx_overrun_q <= 1'b1;
      else if (bus.err_clr)                                        rx_overrun_q <= 1'b0;

      if (complete)         rx_seen_q <= 1'b1;
      else if (bus.err_clr) rx_seen_q <= 1'b0;

      if (complete) since_q <= '0;
      else if ((state_q == ST_SHIFT) && !ss_rise && sample_ev && (since_q != (CNT_W+1)'(DATA_W)))
        since_q <= since_q + (CNT_W+1)'(1);
    end
  end

  assign bus.tx_underrun = tx_underrun_q;
  assign bus.rx_overrun  = rx_overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_shift.sv
// Directed bench for spi_slave_shift: stimulus pushes expectations into queues,
// a negedge monitor pops and compares on rx_valid and on each captured miso word.
module tb_spi_slave_shift;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_shift_if #(.DATA_W(DATA_W)) bus ();

  spi_slave_shift #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_samp = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] got_miso[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      if (exp_rx.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexpected: got rx_valid with %0h expected none", bus.rx_data);
      end else begin
        chk("rx_data", bus.rx_data, exp_rx.pop_front());
        chk("rx_latency", cyc - last_samp, SYNC_STAGES + 1);
      end
    end
    if (got_miso.size() != 0) begin
      if (exp_miso.size() == 0) begin
        checks++; errors++;
        $display("FAIL miso_unexpected: got %0h expected none", got_miso.pop_front());
      end else begin
        chk("miso_word", got_miso.pop_front(), exp_miso.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_reset();
    chk("rst_miso", bus.miso, 0);
    chk("rst_miso_oe", bus.miso_oe, 0);
    chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_busy", bus.busy, 0);
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL push_timeout: tx_ready stayed %0d, required 1", bus.tx_ready);
    end
    tick(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic ss_low(input logic ckp, input logic cke);
    bus.CKP = ckp;
    bus.CKE = cke;
    bus.sck = ckp;
    tick(4);
    bus.ss_n = 1'b0;
    tick(8);
    chk("busy_on", bus.busy, 1);
  endtask

  task automatic xfer(input logic [7:0] m, input int nbits, input logic record);
    logic [7:0] cap = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!bus.CKE) begin
        bus.mosi = m[7-i];
        tick(HALF);
        bus.sck = ~bus.CKP;
        cap = {cap[6:0], bus.miso};
        last_samp = cyc;
        tick(HALF);
        bus.sck = bus.CKP;
      end else begin
        bus.sck = ~bus.CKP;
        bus.mosi = m[7-i];
        tick(HALF);
        bus.sck = bus.CKP;
        cap = {cap[6:0], bus.miso};
        last_samp = cyc;
        tick(HALF);
      end
    end
    if (record) got_miso.push_back(cap);
  endtask

  task automatic ss_high();
    tick(HALF);
    bus.ss_n = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    @(negedge clk);
    chk("miso_oe_off", bus.miso_oe, 0);
    chk("busy_off", bus.busy, 0);
    tick(6);
  endtask

  initial begin
    bus.CKP = 1'b0; bus.CKE = 1'b0; bus.sck = 1'b0; bus.ss_n = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = '0; bus.tx_valid = 1'b0;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    bus.err_clr = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    tick(2);

    // mode CKP=0/CKE=0 basic exchange
    push(8'hA5);
    chk("tx_ready_full", bus.tx_ready, 0);
    exp_miso.push_back(8'hA5); exp_rx.push_back(8'h3C);
    ss_low(1'b0, 1'b0);
    chk("tx_ready_freed", bus.tx_ready, 1);
    xfer(8'h3C, 8, 1'b1);
    ss_high();

    // remaining three modes
    for (int m = 1; m < 4; m++) begin
      logic [1:0] md;
      md = 2'(m);
      push(8'h5A);
      exp_miso.push_back(8'h5A); exp_rx.push_back(8'hC3);
      ss_low(md[1], md[0]);
      xfer(8'hC3, 8, 1'b1);
      ss_high();
    end

    // back-to-back words in one frame
    push(8'h11);
    exp_miso.push_back(8'h11); exp_rx.push_back(8'h81);
    exp_miso.push_back(8'h22); exp_rx.push_back(8'h42);
    ss_low(1'b0, 1'b0);
    push(8'h22);
    xfer(8'h81, 8, 1'b1);
    xfer(8'h42, 8, 1'b1);
    ss_high();

    // underrun: nothing offered
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    chk("overrun_set", bus.rx_overrun, 1);
    bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
    @(negedge clk);
    chk("underrun_clr0", bus.tx_underrun, 0);
`endif
    exp_miso.push_back(8'hFF); exp_rx.push_back(8'hE7);
    ss_low(1'b0, 1'b0);
    xfer(8'hE7, 8, 1'b1);
    ss_high();
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    chk("underrun_set", bus.tx_underrun, 1);
    chk("overrun_none", bus.rx_overrun, 0);
    bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
    @(negedge clk);
    chk("underrun_clr", bus.tx_underrun, 0);
`endif

    // abort after 5 bits, then a clean frame
    ss_low(1'b0, 1'b0);
    xfer(8'h9C, 5, 1'b0);
    ss_high();
    chk("abort_rx_hold", bus.rx_data, 8'hE7);
    push(8'h3E);
    exp_miso.push_back(8'h3E); exp_rx.push_back(8'h5D);
    ss_low(1'b0, 1'b1);
    xfer(8'h5D, 8, 1'b1);
    ss_high();

    // reset at bit 3, then a clean frame
    push(8'h77);
    ss_low(1'b0, 1'b0);
    xfer(8'h88, 3, 1'b0);
    rst = 1'b1; bus.ss_n = 1'b1; bus.sck = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    tick(4);
    push(8'h96);
    exp_miso.push_back(8'h96); exp_rx.push_back(8'h69);
    ss_low(1'b1, 1'b0);
    xfer(8'h69, 8, 1'b1);
    ss_high();

    tick(20);
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("miso_queue_drained", exp_miso.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_shift.md
Name: spi_slave_shift

Overview:
- SPI responder (slave) end of the team's SPI master link.
- Fully synchronous to the system `clk`. `sck`, `ss_n` and `mosi` are oversampled through synchronisers, and `sck` edges are detected in the `clk` domain.
- Supports all four CKP/CKE modes.
- One-entry TX holding buffer with a valid/ready handshake. Received words are presented with a single-cycle valid strobe.

Parameters:
- DATA_W, 8, shift word width in bits.
- SYNC_STAGES, 2, synchroniser flops on `sck`, `ss_n` and `mosi` (minimum 2).

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- CKP  in  1  clock idle polarity (0: `sck` idles low; 1: `sck` idles high).
- CKE  in  1  clock edge select (0: sample on leading edge, drive on trailing edge; 1: drive on leading edge, sample on trailing edge).
- sck  in  1  SPI clock from the master; asynchronous.
- ss_n  in  1  slave select, active low; asynchronous.
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial data out, MSB first.
- miso_oe  out  1  tristate enable for `miso`; high only while selected.
- tx_data  in  DATA_W  next word to transmit.
- tx_valid  in  1  `tx_data` is offered.
- tx_ready  out  1  TX holding buffer is empty; transfer occurs when `tx_valid && tx_ready`.
- rx_data  out  DATA_W  last completed received word; held until the next completion.
- rx_valid  out  1  one-`clk` pulse when `rx_data` updates.
- busy  out  1  frame in progress (synchronised `ss_n` low).

Behaviour:
- Reset (synchronous, `rst`=1):
  - FSM goes to IDLE.
  - `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0, `rx_valid`=0, `busy`=0.
  - Holding buffer and shift register are cleared; bit counter is 0.
  - Reset mid-frame aborts the frame immediately. No `rx_valid` is generated.
- Synchronisation and edge detection:
  - Pins are registered through SYNC_STAGES flops.
  - Leading edge: synchronised `sck` leaves the CKP level. Trailing edge: it returns to the CKP level.
  - Edge detect compares the last two synchronised samples.
  - Required operating ratio: `sck` ≤ `clk`/8.
- Mode latch: CKP/CKE are captured on the synchronised `ss_n` falling edge and held for the whole frame. Changes while selected are ignored.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE → LOAD on synchronised `ss_n` fall.
  - LOAD (1 cycle):
    - shift register ← holding buffer if full (buffer then frees, `tx_ready`=1), else all-ones (underrun word).
    - Bit counter ← 0; `miso_oe`=1; `miso`=shift MSB.
  - SHIFT:
    - On each sample edge: shift register ← {shift[DATA_W-2:0], mosi_sync}; counter +1.
    - On each drive edge: `miso` ← new shift MSB.
    - In CKE=1 mode, the first leading edge is a drive edge; the MSB is already driven from LOAD, so that first drive edge is suppressed.
    - When the counter reaches DATA_W on a sample edge:
      - `rx_data` ← assembled word.
      - `rx_valid`=1 for the next `clk` only (SYNC_STAGES+1 `clk` after the pin edge).
      - Counter wraps to 0; shift register reloads as in LOAD (back-to-back words in one frame).
  - SHIFT or LOAD → IDLE on synchronised `ss_n` rise: partial word discarded, no `rx_valid`, `miso_oe`=0 on the next `clk`.
- Holding buffer:
  - `tx_ready` is the inverse of buffer-full.
  - A handshake in the same cycle as a LOAD or reload is accepted. The load consumes the old contents first and the new word is stored, so no word is lost.
- Simultaneous events: `ss_n` rise and the final sample edge in the same cycle → `ss_n` wins; the word is discarded.
- `rx_valid` has no backpressure. A new completion overwrites `rx_data`.

Optional Feature:
- Macro: SPI_SLAVE_ERR_FLAGS_EN.
- When defined:
  - Adds outputs `tx_underrun` and `rx_overrun` (sticky) and input `err_clr`.
  - `tx_underrun` sets when LOAD or a reload finds the buffer empty.
  - `rx_overrun` sets when a completion occurs within DATA_W sample edges of the previous one while `err_clr` has not been pulsed.
  - Both flags clear on `err_clr`=1 or `rst`. A set condition and `err_clr` in the same cycle → set wins.
- When undefined: the ports are absent; behaviour is otherwise identical.

Decomposition:
- Package `spi_pkg`:
  - state enum (IDLE/LOAD/SHIFT);
  - mode-decode helper giving sample/drive edge selection from CKP/CKE;
  - underrun fill constant (all ones).
- One sub-module, `spi_sync_edge`: SYNC_STAGES synchroniser plus rise/fall detect. Instantiated for `sck` and `ss_n`; `mosi` uses the synchroniser only.

Test Plan:
- Mode 0 (CKP=0, CKE=0): push `tx_data`=0xA5, master sends 0x3C → `miso` bits 1,0,1,0,0,1,0,1; `rx_data`=0x3C with one `rx_valid` pulse.
- Modes 1/2/3: same exchange with tx 0x5A and rx 0xC3 in each mode → identical data results; sample edge checked against mode.
- Back-to-back words: push 0x11 then 0x22 during the frame, master sends 0x81, 0x42 in one `ss_n` low → `rx_valid` twice (0x81, 0x42); `miso` carries 0x11 then 0x22.
- Underrun: frame with no `tx_valid` → `miso` sends 0xFF; with SPI_SLAVE_ERR_FLAGS_EN, `tx_underrun`=1 until `err_clr`.
- Abort: `ss_n` rises after 5 bits → no `rx_valid`, `rx_data` unchanged, `miso_oe`=0 within SYNC_STAGES+1 `clk`; next frame starts at bit 0.
- Reset mid-frame at bit 3 → all outputs reach reset values on the next `clk`; the following full frame completes correctly.
